// File: rtl/spi32_pkg.sv
// ============================================================================
// Module : spi32_pkg
// Shared state encoding, word geometry and byte-mask helper for spi32_target.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spi32_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_BITS  = 8;
    localparam int WORD_BITS  = WORD_BYTES * BYTE_BITS;

    // Keep only the lowest n bytes of a word, zeroing the rest.
    function automatic logic [WORD_BITS-1:0] keep_bytes(input logic [WORD_BITS-1:0] word,
                                                        input logic [2:0] n);
        logic [WORD_BITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i < int'(n)) mask[i*BYTE_BITS +: BYTE_BITS] = {BYTE_BITS{1'b1}};
        end
        return word & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi32_target_if.sv
// ============================================================================
// Module : spi32_target_if
// SPI pins plus host transmit/receive handshake for spi32_target.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface spi32_target_if;
    import spi32_pkg::*;

    logic                 sclk;
    logic                 cs;
    logic                 sdi;
    logic                 sdo;
    logic                 sdo_oe;
    logic [WORD_BITS-1:0] din;
    logic                 load;
    logic [WORD_BITS-1:0] dout;
    logic                 dout_valid;
    logic [2:0]           nbytes;
    logic                 busy;
    logic                 underrun;

    modport master (
        output sclk, cs, sdi, din, load,
        input  sdo, sdo_oe, dout, dout_valid, nbytes, busy, underrun
    );

    modport slave (
        input  sclk, cs, sdi, din, load,
        output sdo, sdo_oe, dout, dout_valid, nbytes, busy, underrun
    );

endinterface

`default_nettype wire

// File: rtl/spi_sync.sv
// ============================================================================
// Module : spi_sync
// Single-bit multi-flop synchronizer with configurable reset value.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] ff;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) ff <= RESET_VAL;
                else        ff <= d;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) ff <= {STAGES{RESET_VAL}};
                else        ff <= {ff[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = ff[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi32_target.sv
// ============================================================================
// Module : spi32_target
// Mode-0 SPI target moving 32-bit words MSB first, with partial-word receive.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi32_target
    import spi32_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    spi32_target_if.slave bus
);

    localparam logic [3:0] SETTLE = 4'(SYNC_STAGES + 1);

    logic sclk_s, cs_s, sdi_s, sclk_q, cs_q;
    logic [3:0] settle_cnt;
    logic armed;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(bus.sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(bus.cs), .q(cs_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .reset(reset), .d(bus.sdi), .q(sdi_s));

    // A cs already low at reset release must not look like a new select:
    // arm only after the synchronizer has flushed and cs is seen high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
            if (settle_cnt != SETTLE) settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE && cs_s) armed <= 1'b1;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q & armed;
    assign cs_rise   = cs_s & ~cs_q;

    state_t state, state_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cs_fall) state_nx = SHIFT;
            SHIFT:   if (cs_rise) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    logic [WORD_BITS-1:0] tx_buf, tx_sr, rx_word, dout_r;
    logic [6:0]           rx_byte;
    logic [2:0]           bit_cnt, byte_cnt, nbytes_r;
    logic                 fresh, dout_valid_r, underrun_r;

    logic start, boundary, finish_part, avail;
    logic [WORD_BITS-1:0] tx_src;
    assign start       = (state == IDLE) && (state_nx == SHIFT);
    assign boundary    = (state == SHIFT) && (byte_cnt == 3'(WORD_BYTES));
    assign finish_part = (state == SHIFT) && cs_rise && !boundary && (byte_cnt != 3'd0);
    assign avail       = bus.load | fresh;
    assign tx_src      = bus.load ? bus.din : tx_buf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_buf       <= '0;
            tx_sr        <= '0;
            rx_word      <= '0;
            rx_byte      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            fresh        <= 1'b0;
            dout_r       <= '0;
            nbytes_r     <= '0;
            dout_valid_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            dout_valid_r <= 1'b0;
            if (bus.load) tx_buf <= bus.din;

            if (start || boundary) fresh <= 1'b0;
            else if (bus.load)     fresh <= 1'b1;

            if (boundary && !avail) underrun_r <= 1'b1;
            else if (bus.load)      underrun_r <= 1'b0;

            if (start) begin
                tx_sr    <= tx_src;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                rx_byte  <= '0;
                rx_word  <= '0;
            end else if (state == SHIFT) begin
                if (boundary) begin
                    dout_r       <= rx_word;
                    nbytes_r     <= 3'(WORD_BYTES);
                    dout_valid_r <= 1'b1;
                    byte_cnt     <= '0;
                    tx_sr        <= avail ? tx_src : '0;
                end else if (sclk_fall && (bit_cnt != 3'd0 || byte_cnt != 3'd0)) begin
                    // The fall right after a (re)load keeps the fresh MSB on sdo.
                    tx_sr <= {tx_sr[WORD_BITS-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    rx_byte <= {rx_byte[5:0], sdi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(BYTE_BITS - 1)) begin
                        rx_word  <= {rx_word[WORD_BITS-BYTE_BITS-1:0], rx_byte, sdi_s};
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                if (finish_part) begin
                    dout_r       <= keep_bytes(rx_word, byte_cnt);
                    nbytes_r     <= byte_cnt;
                    dout_valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.sdo        = tx_sr[WORD_BITS-1];
    assign bus.sdo_oe     = (state == SHIFT);
    assign bus.busy       = (state != IDLE);
    assign bus.dout       = dout_r;
    assign bus.nbytes     = nbytes_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.underrun   = underrun_r;

endmodule

`default_nettype wire

// File: tb/tb_spi32_target.sv
// ============================================================================
// Module : tb_spi32_target
// Randomized self-checking bench for spi32_target against a word-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spi32_target;
    import spi32_pkg::*;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi32_target_if bus ();

    spi32_target #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every dout_valid pulse: {seen outside SHIFT, nbytes, dout}
    logic [35:0] mon_q[$];
    always @(negedge clk)
        if (reset === 1'b1 && bus.dout_valid === 1'b1)
            mon_q.push_back({~bus.sdo_oe, bus.nbytes, bus.dout});

    // Reference model: transmit buffer, freshness and sticky underrun
    logic [31:0] m_buf;
    bit          m_fresh;
    bit          m_underrun;

    task automatic do_load(input logic [31:0] v);
        @(negedge clk);
        bus.din  = v;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        m_buf = v; m_fresh = 1; m_underrun = 0;
    endtask

    task automatic model_reload(inout logic [31:0] cur);
        cur = m_fresh ? m_buf : 32'h0;
        if (!m_fresh) m_underrun = 1;
        m_fresh = 0;
    endtask

    // Bit i sent is data[127-i]; optional one-cycle load before the rise of bit load_at.
    task automatic xfer(input string tag, input int nbits, input logic [127:0] data,
                        input int load_at, input logic [31:0] load_val);
        logic [127:0] miso, exp_miso, mask;
        logic [31:0]  cur, slice;
        logic [35:0]  exp_q[$];
        int nw, nb;
        miso = '0; exp_miso = '0; mask = '0;
        cur = m_buf; m_fresh = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0 && i % 32 == 0) model_reload(cur);
            if (i == load_at) begin m_buf = load_val; m_fresh = 1; m_underrun = 0; end
            exp_miso[127-i] = cur[31 - (i % 32)];
            mask[127-i] = 1'b1;
        end
        if (nbits % 32 == 0) model_reload(cur);
        nw = nbits / 32;
        for (int j = 0; j < nw; j++) exp_q.push_back({1'b0, 3'd4, data[127-32*j -: 32]});
        nb = (nbits % 32) / 8;
        if (nb > 0) begin
            slice = data[127-32*nw -: 32];
            exp_q.push_back({1'b1, 3'(nb), slice >> (32 - 8*nb)});
        end

        mon_q.delete();
        @(negedge clk);
        bus.cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.sdi = data[127-i];
            if (i == load_at) begin
                bus.din  = load_val;
                bus.load = 1'b1;
                @(negedge clk);
                bus.load = 1'b0;
                repeat (HALF-1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            miso[127-i] = bus.sdo;
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        bus.cs = 1'b1;
        repeat (12) @(negedge clk);

        check({tag, " sdo"}, miso & mask, exp_miso);
        check({tag, " pulses"}, 128'(mon_q.size()), 128'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < mon_q.size(); j++)
            check($sformatf("%s word%0d", tag, j), 128'(mon_q[j]), 128'(exp_q[j]));
        check({tag, " underrun"}, 128'(bus.underrun), 128'(m_underrun));
        check({tag, " busy"}, 128'(bus.busy), 128'(0));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [6:0] out_vec();
        return {bus.busy, bus.sdo_oe, bus.sdo, bus.dout_valid, bus.underrun, bus.nbytes == 3'd0,
                bus.dout == 32'h0};
    endfunction

    initial begin
        int nbits, lat;
        reset = 1'b0;
        bus.sclk = 1'b0; bus.cs = 1'b1; bus.sdi = 1'b0;
        bus.din = '0; bus.load = 1'b0;
        m_buf = '0; m_fresh = 0; m_underrun = 0;
        repeat (3) @(negedge clk);
        check("reset outputs", 128'(out_vec()), 128'(7'b0000011));
        reset = 1'b1;
        repeat (6) @(negedge clk);

        do_load(32'hA5C3_0F81);
        xfer("w32", 32, {32'h1234_5678, 96'h0}, -1, 32'h0);
        xfer("beef", 16, {16'hBEEF, 112'h0}, -1, 32'h0);

        do_load($urandom());
        xfer("w64 underrun", 64, rnd128(), -1, 32'h0);
        do_load($urandom());
        check("underrun cleared by load", 128'(bus.underrun), 128'(0));

        xfer("13 bits", 13, {13'h1FFF, 115'h0}, -1, 32'h0);

        do_load($urandom());
        xfer("w64 midload", 64, rnd128(), 10, 32'h0000_0001);

        // Reset mid-byte with cs held low
        mon_q.delete();
        @(negedge clk);
        bus.cs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.sdi = i[0];
            repeat (HALF) @(negedge clk); bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk); bus.sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async reset outputs", 128'(out_vec()), 128'(7'b0000011));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_buf = '0; m_fresh = 0; m_underrun = 0;
        for (int i = 0; i < 16; i++) begin
            bus.sdi = 1'b1;
            repeat (HALF) @(negedge clk); bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk); bus.sclk = 1'b0;
            if (i == 8) check("idle after reset busy", 128'(bus.busy), 128'(0));
        end
        check("idle after reset outputs", 128'(out_vec()), 128'(7'b0000011));
        check("no pulse after reset", 128'(mon_q.size()), 128'(0));
        bus.cs = 1'b1;
        repeat (10) @(negedge clk);
        xfer("post reset", 24, rnd128(), -1, 32'h0);

        for (int t = 0; t < 8; t++) begin
            nbits = $urandom_range(1, 80);
            if ($urandom_range(0, 1) == 1) do_load($urandom());
            lat = (nbits > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, nbits - 1) : -1;
            xfer($sformatf("rand%0d", t), nbits, rnd128(), lat, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
